// File: rtl/frame_pkg.sv
// ---------------------------------------------------------------------------
// frame_pkg
// Definitions shared by binary_frame_writer and bit_packer:
//   state_t          - writer state machine encoding (S_IDLE, S_ACTIVE)
//   FRAME_ADDR_W     - width of the image memory byte address
//   FG_COUNT_W       - width of the optional foreground pixel counter
//   bytes_per_frame  - packed bytes in one WIDTH x HEIGHT binary image
//   pixel_bit        - binarization rule (luma at or above level -> 1)
// ---------------------------------------------------------------------------
package frame_pkg;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   localparam int FRAME_ADDR_W = 16;
   localparam int FG_COUNT_W   = 19;

   // Eight binary pixels share one memory byte.
   function automatic int bytes_per_frame(input int width, input int height);
      return (width * height) / 8;
   endfunction

   // A pixel is foreground when its luma reaches the latched level.
   function automatic logic pixel_bit(input logic [7:0] luma, input logic [7:0] level);
      return (luma >= level) ? 1'b1 : 1'b0;
   endfunction

endpackage

// File: rtl/bit_packer.sv
// ---------------------------------------------------------------------------
// bit_packer
// Assembles eight consecutive binary pixels into one byte, LSB first: the
// first bit accepted after a clear lands in bit 0 of the finished byte.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   px_bit       - incoming binary pixel
//   valid        - px_bit is accepted this cycle
//   clear        - drop any partial byte; if valid is also high, px_bit
//                  becomes bit 0 of a fresh byte
//   packed_byte  - registered finished byte (holds until the next byte)
//   byte_valid   - one-cycle pulse, the cycle after the 8th bit is accepted
// ---------------------------------------------------------------------------
module bit_packer
   import frame_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       px_bit,
   input  logic       valid,
   input  logic       clear,
   output logic [7:0] packed_byte,
   output logic       byte_valid
);

   logic [7:0] shift_r;
   logic [2:0] count_r;
   logic [7:0] byte_r;
   logic       byte_valid_r;

   logic [7:0] shift_base_s;
   logic [2:0] count_base_s;
   logic [7:0] shift_next_s;
   logic       done_s;

   // Next shift contents; a clear restarts assembly before this cycle's bit is taken.
   always_comb begin
      shift_base_s = shift_r;
      count_base_s = count_r;
      if (clear) begin
         shift_base_s = 8'h00;
         count_base_s = 3'd0;
      end else begin
         shift_base_s = shift_r;
         count_base_s = count_r;
      end
      // Shifting in from the top leaves the oldest of eight bits in bit 0.
      shift_next_s = {px_bit, shift_base_s[7:1]};
      done_s       = valid && (count_base_s == 3'd7);
   end

   // Shift register, bit counter and registered byte output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_r      <= 8'h00;
         count_r      <= 3'd0;
         byte_r       <= 8'h00;
         byte_valid_r <= 1'b0;
      end else begin
         if (valid) begin
            shift_r <= shift_next_s;
            count_r <= count_base_s + 3'd1;
         end else begin
            shift_r <= shift_base_s;
            count_r <= count_base_s;
         end
         if (done_s) begin
            byte_r <= shift_next_s;
         end else begin
            byte_r <= byte_r;
         end
         byte_valid_r <= done_s;
      end
   end

   assign packed_byte = byte_r;
   assign byte_valid  = byte_valid_r;

endmodule

// File: rtl/binary_frame_writer.sv
// ---------------------------------------------------------------------------
// binary_frame_writer
// Thresholds a raster-scanned grayscale stream into a 1-bit image and writes
// it to a byte-wide image memory, eight pixels per byte (lowest x in bit 0).
// Parameters:
//   WIDTH  - pixels per line (multiple of 8)
//   HEIGHT - lines per frame (WIDTH*HEIGHT/8 <= 65536)
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   sof         - start of frame, qualified by px_valid, marks pixel (0,0)
//   px_valid    - a pixel is presented this cycle
//   luma        - 8-bit grayscale pixel
//   threshold   - binarization level, latched at each accepted sof
//   wraddress   - memory byte address, y*(WIDTH/8) + x/8
//   data        - packed pixel byte
//   wren        - one-cycle write strobe, the cycle after a byte completes
//   frame_done  - pulses together with the final write of a frame
//   frame_err   - pulses the cycle after a frame is aborted by an early sof
//   fg_count    - (only with BINARY_FRAME_WRITER_STATS_EN defined) number of
//                 foreground pixels in the last completed frame
// Build option: define BINARY_FRAME_WRITER_STATS_EN to add fg_count.
// ---------------------------------------------------------------------------
module binary_frame_writer
   import frame_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sof,
   input  logic                    px_valid,
   input  logic [7:0]              luma,
   input  logic [7:0]              threshold,
   output logic [FRAME_ADDR_W-1:0] wraddress,
   output logic [7:0]              data,
   output logic                    wren,
   output logic                    frame_done,
   output logic                    frame_err
`ifdef BINARY_FRAME_WRITER_STATS_EN
   ,
   output logic [FG_COUNT_W-1:0]   fg_count
`endif
);

   localparam int XW             = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW             = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int BYTES_PER_LINE = WIDTH / 8;
   localparam int FRAME_BYTES    = bytes_per_frame(WIDTH, HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);

   state_t                  state_r;
   state_t                  state_next_s;
   logic [XW-1:0]           x_r;
   logic [YW-1:0]           y_r;
   logic [XW-1:0]           x_next_s;
   logic [YW-1:0]           y_next_s;
   logic [7:0]              thr_r;
   logic [7:0]              thr_next_s;
   logic [FRAME_ADDR_W-1:0] wraddress_r;
   logic                    frame_done_r;
   logic                    frame_err_r;

   logic                    accept_s;
   logic                    start_s;
   logic                    abort_s;
   logic [XW-1:0]           pos_x_s;
   logic [YW-1:0]           pos_y_s;
   logic [7:0]              thr_eff_s;
   logic                    px_bit_s;
   logic                    byte_end_s;
   logic                    last_s;
   logic [31:0]             byte_idx_s;

   // Pixel acceptance and frame start/abort decode for the current state.
   always_comb begin
      accept_s = 1'b0;
      start_s  = 1'b0;
      abort_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            // Only a qualified sof opens a frame; other pixels are dropped.
            start_s  = sof && px_valid;
            accept_s = sof && px_valid;
         end
         S_ACTIVE: begin
            accept_s = px_valid;
            start_s  = sof && px_valid;
            abort_s  = sof && px_valid && ((x_r != {XW{1'b0}}) || (y_r != {YW{1'b0}}));
         end
         default: begin
            accept_s = 1'b0;
            start_s  = 1'b0;
            abort_s  = 1'b0;
         end
      endcase
   end

   // Position, binarized bit and byte address of the pixel on the inputs.
   always_comb begin
      if (start_s) begin
         // The sof pixel is (0,0) and already uses the threshold being latched.
         pos_x_s   = {XW{1'b0}};
         pos_y_s   = {YW{1'b0}};
         thr_eff_s = threshold;
      end else begin
         pos_x_s   = x_r;
         pos_y_s   = y_r;
         thr_eff_s = thr_r;
      end
      px_bit_s   = pixel_bit(luma, thr_eff_s);
      byte_end_s = accept_s && (pos_x_s[2:0] == 3'b111);
      byte_idx_s = 32'(pos_y_s) * 32'(BYTES_PER_LINE) + 32'(pos_x_s >> 3);
      // The frame ends with the byte that holds pixel (WIDTH-1, HEIGHT-1).
      last_s     = byte_end_s && (byte_idx_s == 32'(FRAME_BYTES - 1));
   end

   // Next state, raster position and latched threshold.
   always_comb begin
      state_next_s = state_r;
      x_next_s     = x_r;
      y_next_s     = y_r;
      thr_next_s   = thr_r;
      if (start_s) begin
         thr_next_s = threshold;
      end else begin
         thr_next_s = thr_r;
      end
      if (accept_s) begin
         if (last_s) begin
            state_next_s = S_IDLE;
            x_next_s     = {XW{1'b0}};
            y_next_s     = {YW{1'b0}};
         end else if (pos_x_s == X_LAST) begin
            state_next_s = S_ACTIVE;
            x_next_s     = {XW{1'b0}};
            y_next_s     = pos_y_s + YW'(1'b1);
         end else begin
            state_next_s = S_ACTIVE;
            x_next_s     = pos_x_s + XW'(1'b1);
            y_next_s     = pos_y_s;
         end
      end else begin
         state_next_s = state_r;
         x_next_s     = x_r;
         y_next_s     = y_r;
      end
   end

   // State, position, threshold and registered address/status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= S_IDLE;
         x_r          <= {XW{1'b0}};
         y_r          <= {YW{1'b0}};
         thr_r        <= 8'h00;
         wraddress_r  <= {FRAME_ADDR_W{1'b0}};
         frame_done_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         x_r     <= x_next_s;
         y_r     <= y_next_s;
         thr_r   <= thr_next_s;
         if (byte_end_s) begin
            // Address is captured with the 8th bit so it aligns with wren.
            wraddress_r <= FRAME_ADDR_W'(byte_idx_s);
         end else begin
            wraddress_r <= wraddress_r;
         end
         frame_done_r <= last_s;
         frame_err_r  <= abort_s;
      end
   end

   // A new frame (normal or abort) clears any partial byte before packing.
   bit_packer u_bit_packer (
      .clk         (clk),
      .reset       (reset),
      .px_bit      (px_bit_s),
      .valid       (accept_s),
      .clear       (start_s),
      .packed_byte (data),
      .byte_valid  (wren)
   );

   assign wraddress  = wraddress_r;
   assign frame_done = frame_done_r;
   assign frame_err  = frame_err_r;

`ifdef BINARY_FRAME_WRITER_STATS_EN
   logic [FG_COUNT_W-1:0] fg_acc_r;
   logic [FG_COUNT_W-1:0] fg_count_r;
   logic [FG_COUNT_W-1:0] fg_base_s;
   logic [FG_COUNT_W-1:0] fg_sum_s;

   // Running foreground count; a frame start discards the previous tally.
   always_comb begin
      if (start_s) begin
         fg_base_s = {FG_COUNT_W{1'b0}};
      end else begin
         fg_base_s = fg_acc_r;
      end
      fg_sum_s = fg_base_s + {{(FG_COUNT_W-1){1'b0}}, px_bit_s};
   end

   // Accumulator and published count; publishing only on the last pixel
   // keeps aborted frames from touching fg_count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fg_acc_r   <= {FG_COUNT_W{1'b0}};
         fg_count_r <= {FG_COUNT_W{1'b0}};
      end else begin
         if (accept_s) begin
            fg_acc_r <= fg_sum_s;
         end else begin
            fg_acc_r <= fg_acc_r;
         end
         if (last_s) begin
            fg_count_r <= fg_sum_s;
         end else begin
            fg_count_r <= fg_count_r;
         end
      end
   end

   assign fg_count = fg_count_r;
`endif

endmodule

// File: tb/tb_binary_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_binary_frame_writer
// Directed sequence with random images and gaps for a 16x4 instance, plus a
// 640x480 instance fed four lines of a diagonal pattern. Expected writes come
// from a flat pixel-index model: byte b holds pixels 8b..8b+7, address b.
// ---------------------------------------------------------------------------
module tb_binary_frame_writer;

   localparam int W    = 16;
   localparam int H    = 4;
   localparam int NPIX = W * H;
   localparam int NB   = NPIX / 8;
   localparam int BW   = 640;
   localparam int BH   = 480;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sof = 1'b0;
   logic        px_valid = 1'b0;
   logic [7:0]  luma = 8'h00;
   logic [7:0]  threshold = 8'h00;
   logic [15:0] wraddress;
   logic [7:0]  data;
   logic        wren, frame_done, frame_err;

   logic        big_sof = 1'b0;
   logic        big_px_valid = 1'b0;
   logic [7:0]  big_luma = 8'h00;
   logic [7:0]  big_threshold = 8'h00;
   logic [15:0] big_wraddress;
   logic [7:0]  big_data;
   logic        big_wren, big_frame_done, big_frame_err;
`ifdef BINARY_FRAME_WRITER_STATS_EN
   logic [18:0] fg_count, big_fg_count;
`endif

   binary_frame_writer #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk(clk), .reset(reset), .sof(sof), .px_valid(px_valid), .luma(luma),
      .threshold(threshold), .wraddress(wraddress), .data(data), .wren(wren),
      .frame_done(frame_done), .frame_err(frame_err)
`ifdef BINARY_FRAME_WRITER_STATS_EN
      , .fg_count(fg_count)
`endif
   );

   binary_frame_writer #(.WIDTH(BW), .HEIGHT(BH)) dut_big (
      .clk(clk), .reset(reset), .sof(big_sof), .px_valid(big_px_valid), .luma(big_luma),
      .threshold(big_threshold), .wraddress(big_wraddress), .data(big_data), .wren(big_wren),
      .frame_done(big_frame_done), .frame_err(big_frame_err)
`ifdef BINARY_FRAME_WRITER_STATS_EN
      , .fg_count(big_fg_count)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- write monitors (sampled on the falling edge) ----------
   int   wr_addr_q[$];
   int   wr_data_q[$];
   int   wr_done_q[$];
   int   done_alone = 0;
   int   err_pulses = 0;
   int   err_long = 0;
   int   err_cyc = -1;
   logic err_prev = 1'b0;

   always @(negedge clk) begin
      if (wren === 1'b1) begin
         wr_addr_q.push_back(int'(wraddress));
         wr_data_q.push_back(int'(data));
         wr_done_q.push_back(int'(frame_done));
      end else if (frame_done === 1'b1) begin
         done_alone++;
      end
      if (frame_err === 1'b1) begin
         err_pulses++;
         err_cyc = cyc;
         if (err_prev === 1'b1) err_long++;
      end
      err_prev = frame_err;
   end

   int big_addr_q[$];
   int big_data_q[$];
   int big_flags = 0;

   always @(negedge clk) begin
      if (big_wren === 1'b1) begin
         big_addr_q.push_back(int'(big_wraddress));
         big_data_q.push_back(int'(big_data));
      end
      if (big_frame_done === 1'b1 || big_frame_err === 1'b1) big_flags++;
   end

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_done_q.delete();
      done_alone = 0;
      err_pulses = 0;
      err_long   = 0;
      err_cyc    = -1;
   endtask

   // ---------------- reference model ----------------
   logic [7:0] img [NPIX];
   int exp_addr_q[$];
   int exp_data_q[$];
   int exp_done_q[$];

   function automatic logic [7:0] model_byte(input int b, input logic [7:0] th);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) r[i] = (img[b*8 + i] >= th);
      return r;
   endfunction

   // Writes expected for the first npix pixels of the current image.
   task automatic expect_bytes(input logic [7:0] th, input int npix, input bit whole);
      for (int b = 0; b < npix / 8; b++) begin
         exp_addr_q.push_back(b);
         exp_data_q.push_back(int'(model_byte(b, th)));
         exp_done_q.push_back((whole && b == NB - 1) ? 1 : 0);
      end
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check({tag, " write count"}, wr_addr_q.size(), exp_addr_q.size());
      n = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s[%0d] addr", tag, i), wr_addr_q[i], exp_addr_q[i]);
         check($sformatf("%s[%0d] data", tag, i), wr_data_q[i], exp_data_q[i]);
         check($sformatf("%s[%0d] done", tag, i), wr_done_q[i], exp_done_q[i]);
      end
      check({tag, " done outside write"}, done_alone, 0);
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_done_q.delete();
   endtask

   function automatic int dup_count();
      int d;
      d = 0;
      for (int i = 0; i < wr_addr_q.size(); i++)
         for (int j = i + 1; j < wr_addr_q.size(); j++)
            if (wr_addr_q[i] == wr_addr_q[j]) d++;
      return d;
   endfunction

   task automatic fill_random(input logic [7:0] th);
      for (int i = 0; i < NPIX; i++)
         img[i] = ($urandom_range(3, 0) == 0) ? th : 8'($urandom);
   endtask

   task automatic fill_const(input logic [7:0] v);
      for (int i = 0; i < NPIX; i++) img[i] = v;
   endtask

   // ---------------- drivers ----------------
   int last_sof_cyc = 0;

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         px_valid = 1'b0;
         sof      = 1'b0;
      end
   endtask

   // One pixel, then 0..gmax gap cycles with random (ignored) sof/luma.
   task automatic drive_px(input logic s, input logic [7:0] lu, input logic [7:0] th, input int gmax);
      int g;
      @(negedge clk);
      sof       = s;
      px_valid  = 1'b1;
      luma      = lu;
      threshold = th;
      if (s) last_sof_cyc = cyc;
      g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      repeat (g) begin
         @(negedge clk);
         px_valid  = 1'b0;
         sof       = 1'($urandom);
         luma      = 8'($urandom);
         threshold = 8'($urandom);
      end
   endtask

   // threshold only matters at sof; it is scrambled elsewhere to test latching.
   task automatic send_frame(input logic [7:0] th, input int npix, input int gmax);
      for (int i = 0; i < npix; i++)
         drive_px(i == 0, img[i], (i == 0) ? th : 8'($urandom), gmax);
   endtask

   function automatic bit is_diag(input int x, input int y);
      return (y == 1 && (x == 1 || x == 10)) || (y == 2 && (x == 3 || x == 12)) ||
             (y == 3 && (x == 5 || x == 14));
   endfunction

   function automatic int big_data_at(input int a);
      for (int i = 0; i < big_addr_q.size(); i++)
         if (big_addr_q[i] == a) return big_data_q[i];
      return -1;
   endfunction

   logic [7:0] th_list [3];

   initial begin
      logic [7:0] th, th2;
      int nz;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("reset wren", wren, 1'b0);
      check("reset data", data, 8'h00);
      check("reset wraddress", wraddress, 16'h0000);
      check("reset frame_done", frame_done, 1'b0);
      check("reset frame_err", frame_err, 1'b0);
      check("reset big wren", big_wren, 1'b0);
`ifdef BINARY_FRAME_WRITER_STATS_EN
      check("reset fg_count", fg_count, 19'd0);
`endif
      reset = 1'b0;
      idle(2);

      // ---- pixels before any sof are ignored ----
      clear_mon();
      for (int i = 0; i < 20; i++) drive_px(1'b0, 8'hff, 8'h00, 0);
      idle(3);
      check("idle ignores pixels", wr_addr_q.size(), 0);

      // ---- single foreground pixel at (8,0) ----
      fill_const(8'h00);
      img[8] = 8'd200;
      clear_mon();
      expect_bytes(8'd128, NPIX, 1'b1);
      send_frame(8'd128, NPIX, 0);
      idle(3);
      check("single px byte1", (wr_data_q.size() > 1) ? wr_data_q[1] : -1, 32'h01);
      compare_writes("single_px");

      // ---- random images, gap-free vs gapped, boundary thresholds ----
      th_list[0] = 8'h00;
      th_list[1] = 8'hff;
      th_list[2] = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
         th = th_list[k];
         fill_random(th);
         clear_mon();
         expect_bytes(th, NPIX, 1'b1);
         send_frame(th, NPIX, 0);
         idle(3);
         compare_writes($sformatf("rand%0d nogap", k));
         clear_mon();
         expect_bytes(th, NPIX, 1'b1);
         send_frame(th, NPIX, 5);
         idle(3);
         check($sformatf("rand%0d gap dup addr", k), dup_count(), 0);
         compare_writes($sformatf("rand%0d gap", k));
      end

      // ---- back-to-back frames, sof right after the last pixel ----
      th  = 8'd90;
      th2 = 8'd170;
      fill_random(th);
      clear_mon();
      expect_bytes(th, NPIX, 1'b1);
      expect_bytes(th2, NPIX, 1'b1);
      send_frame(th, NPIX, 0);
      send_frame(th2, NPIX, 0);
      idle(3);
      check("b2b err", err_pulses, 0);
      compare_writes("b2b");

      // ---- abort after 13 pixels ----
      th = 8'd128;
      fill_random(th);
      clear_mon();
      expect_bytes(th, 13, 1'b0);
      send_frame(th, 13, 0);
      th2 = 8'd60;
      fill_random(th2);
      expect_bytes(th2, NPIX, 1'b1);
      send_frame(th2, NPIX, 0);
      idle(3);
      check("abort err pulses", err_pulses, 1);
      check("abort err width", err_long, 0);
      check("abort err timing", err_cyc, last_sof_cyc + 1);
      compare_writes("abort");

      // ---- asynchronous reset mid-frame ----
      th = 8'd100;
      fill_random(th);
      clear_mon();
      send_frame(th, 16, 0);
      @(posedge clk);
      #2;
      check("pre-reset wren", wren, 1'b1);
      reset = 1'b1;
      #1;
      check("async reset wren", wren, 1'b0);
      check("async reset data", data, 8'h00);
      check("async reset wraddress", wraddress, 16'h0000);
      @(negedge clk);
      px_valid = 1'b0;
      sof      = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      clear_mon();
      for (int i = 0; i < 24; i++) drive_px(1'b0, 8'hff, 8'h00, 0);
      idle(3);
      check("post-reset no writes", wr_addr_q.size(), 0);
      check("post-reset no err", err_pulses, 0);
      fill_random(th);
      expect_bytes(th, NPIX, 1'b1);
      send_frame(th, NPIX, 2);
      idle(3);
      compare_writes("post-reset frame");

      // ---- 640x480 diagonal, first four lines ----
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < BW; x++) begin
            @(negedge clk);
            big_sof       = (x == 0 && y == 0);
            big_px_valid  = 1'b1;
            big_luma      = is_diag(x, y) ? 8'd255 : 8'd0;
            big_threshold = (x == 0 && y == 0) ? 8'd128 : 8'($urandom);
         end
      end
      @(negedge clk);
      big_px_valid = 1'b0;
      big_sof      = 1'b0;
      idle(3);
      check("big write count", big_addr_q.size(), 4 * BW / 8);
      check("big @80", big_data_at(80), 32'h02);
      check("big @81", big_data_at(81), 32'h04);
      check("big @160", big_data_at(160), 32'h08);
      check("big @161", big_data_at(161), 32'h10);
      check("big @240", big_data_at(240), 32'h20);
      check("big @241", big_data_at(241), 32'h40);
      nz = 0;
      for (int i = 0; i < big_addr_q.size(); i++)
         if (!(big_addr_q[i] inside {80, 81, 160, 161, 240, 241}) && big_data_q[i] != 0) nz++;
      check("big others zero", nz, 0);
      check("big no done/err", big_flags, 0);

`ifdef BINARY_FRAME_WRITER_STATS_EN
      // ---- foreground count ----
      check("big fg_count", big_fg_count, 19'd0);
      th = 8'd90;
      fill_const(8'd89);
      img[0]  = th;
      img[7]  = th;
      img[20] = th;
      img[33] = th;
      img[63] = th;
      clear_mon();
      send_frame(th, NPIX, 2);
      idle(3);
      check("fg_count frame", fg_count, 19'd5);
      fill_const(8'hff);
      send_frame(th, 13, 0);
      fill_const(8'h00);
      send_frame(th, 20, 0);
      idle(3);
      check("fg_count abort err", err_pulses, 1);
      check("fg_count after abort", fg_count, 19'd5);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
